clk_div_pwm: RTL and testbench

Clock divider with a programmable duty cycle. It divides `clk_in` by a fixed period and drives `clk_out` as a PWM waveform. The high time is stepped up or down by rising edges on the `inc` and `dec` request inputs. It sits between the system clock and downstream logic that needs a slower clock or a PWM enable.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_rise_detect.sv | 21 ++
 rtl/clk_div_pwm.sv | 82 ++++++++
 tb/tb_clk_div_pwm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults and register-width helper for the PWM clock divider.
package clk_div_pkg;

    localparam int PERIOD_DEF    = 10;
    localparam int DUTY_INIT_DEF = 5;
    localparam int DUTY_STEP_DEF = 1;

    // Bits needed to hold every value in 0..max_val, never less than one.
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_div_rise_detect.sv
// Single-register rising-edge detector for a level request input.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/clk_div_pwm.sv
// Clock divider with PWM duty stepped by inc/dec requests; duty changes take
// effect only at a period boundary so no period is ever truncated.
module clk_div_pwm
    import clk_div_pkg::*;
#(
    parameter int PERIOD    = PERIOD_DEF,
    parameter int DUTY_INIT = DUTY_INIT_DEF,
    parameter int DUTY_STEP = DUTY_STEP_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic clk_out
);

    localparam int CW     = width_for(PERIOD - 1);
    localparam int DW     = width_for(PERIOD);
    localparam int STEP_C = (DUTY_STEP > PERIOD) ? PERIOD : DUTY_STEP;

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [DW:0]   PERIOD_X = (DW + 1)'(PERIOD);
    localparam logic [DW:0]   STEP_X   = (DW + 1)'(STEP_C);
    localparam logic [DW-1:0] DUTY_RST = DW'(DUTY_INIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] duty_pend_q, duty_pend_d;
    logic [DW-1:0] duty_act_q, duty_act_d;
    logic          clk_out_q, clk_out_d;
    logic          inc_rise, dec_rise;
    logic          wrap;
    logic [DW:0]   pend_x, sum_x, diff_x;

    rise_detect u_inc_rise (
        .clk_i  (clk_in),
        .rst_ni (rst),
        .d_i    (inc),
        .rise_o (inc_rise)
    );

    rise_detect u_dec_rise (
        .clk_i  (clk_in),
        .rst_ni (rst),
        .d_i    (dec),
        .rise_o (dec_rise)
    );

    assign wrap = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d       = wrap ? '0 : cnt_q + CW'(1);
        // One extra bit so the saturation compare sees the true sum.
        pend_x      = {1'b0, duty_pend_q};
        sum_x       = pend_x + STEP_X;
        diff_x      = pend_x - STEP_X;
        duty_pend_d = duty_pend_q;
        if (inc_rise && !dec_rise) begin
            duty_pend_d = (sum_x > PERIOD_X) ? DW'(PERIOD_X) : DW'(sum_x);
        end else if (dec_rise && !inc_rise) begin
            duty_pend_d = (pend_x < STEP_X) ? '0 : DW'(diff_x);
        end
        duty_act_d  = wrap ? duty_pend_q : duty_act_q;
        clk_out_d   = (DW'(cnt_q) < duty_act_q);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            duty_pend_q <= DUTY_RST;
            duty_act_q  <= DUTY_RST;
            clk_out_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
            clk_out_q   <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;

endmodule

// File: tb/tb_clk_div_pwm.sv
// Self-checking bench for clk_div_pwm: cycle model feeds an expected-output
// queue that is drained against the DUT on every falling edge.
module tb_clk_div_pwm;

    localparam int P    = 10;
    localparam int INIT = 5;
    localparam int STEP = 1;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    logic inc    = 1'b0;
    logic dec    = 1'b0;
    logic clk_out;

    int checks = 0;
    int errors = 0;

    bit exp_q[$];

    int  m_cnt  = 0;
    int  m_pend = INIT;
    int  m_act  = INIT;
    bit  m_inc_q = 1'b0;
    bit  m_dec_q = 1'b0;

    clk_div_pwm #(
        .PERIOD    (P),
        .DUTY_INIT (INIT),
        .DUTY_STEP (STEP)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .inc     (inc),
        .dec     (dec),
        .clk_out (clk_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: produces the value clk_out must hold after each edge.
    always @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            m_cnt   = 0;
            m_pend  = INIT;
            m_act   = INIT;
            m_inc_q = 1'b0;
            m_dec_q = 1'b0;
            exp_q.delete();
        end else begin
            bit ri, rd;
            int old_pend;
            exp_q.push_back(m_cnt < m_act);
            ri = inc && !m_inc_q;
            rd = dec && !m_dec_q;
            old_pend = m_pend;
            if (ri && !rd)      m_pend = (m_pend + STEP > P) ? P : m_pend + STEP;
            else if (rd && !ri) m_pend = (m_pend - STEP < 0) ? 0 : m_pend - STEP;
            if (m_cnt == P - 1) m_act = old_pend;
            m_cnt   = (m_cnt + 1) % P;
            m_inc_q = inc;
            m_dec_q = dec;
        end
    end

    always @(negedge clk_in) begin
        if (rst && exp_q.size() > 0) begin
            bit e;
            e = exp_q.pop_front();
            check("clk_out_sb", int'(clk_out), int'(e));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic count_high(input string tag, input int exp_high);
        int hi = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk_in);
            if (clk_out === 1'b1) hi++;
        end
        check(tag, hi, exp_high);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b0;
        inc = 1'b0;
        dec = 1'b0;
        cycles(2);
        rst = 1'b1;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc = 1'b1; cycles(1);
            inc = 1'b0; cycles(1);
        end
    endtask

    task automatic pulse_dec(input int n);
        for (int i = 0; i < n; i++) begin
            dec = 1'b1; cycles(1);
            dec = 1'b0; cycles(1);
        end
    endtask

    initial begin
        int found;

        // reset and default waveform
        @(negedge clk_in);
        check("rst_out0", int'(clk_out), 0);
        @(negedge clk_in);
        check("rst_out1", int'(clk_out), 0);
        rst = 1'b1;
        cycles(20);
        count_high("default_duty", 5);

        // single inc mid-period
        cycles(3);
        pulse_inc(1);
        cycles(25);
        count_high("single_inc", 6);

        // held inc, then saturation
        do_reset();
        inc = 1'b1;
        cycles(30);
        count_high("held_inc", 6);
        cycles(10);
        inc = 1'b0;
        cycles(1);
        pulse_inc(10);
        cycles(20);
        count_high("sat_high", 10);

        // dec to zero
        do_reset();
        cycles(4);
        pulse_dec(7);
        cycles(20);
        count_high("sat_low", 0);

        // simultaneous rise
        do_reset();
        cycles(6);
        inc = 1'b1; dec = 1'b1;
        cycles(1);
        inc = 1'b0; dec = 1'b0;
        cycles(20);
        count_high("simul_req", 5);

        // mid-period reset from duty 8
        do_reset();
        pulse_inc(3);
        cycles(20);
        count_high("duty8", 8);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk_in);
            if (clk_out === 1'b1) found = 1;
        end
        check("pre_rst_high", found, 1);
        #2 rst = 1'b0;
        #1 check("async_rst_out", int'(clk_out), 0);
        cycles(2);
        check("rst_hold_out", int'(clk_out), 0);
        rst = 1'b1;
        cycles(20);
        count_high("post_rst_duty", 5);

        cycles(2);
        check("sb_drained", exp_q.size() <= 1 ? 1 : 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
